// File: rtl/step_sched_pkg.sv
// Shared types and helpers for the round-robin step-counter scheduler.
// Holds the scheduler state encoding, the step-mode constants and the step-increment rule.
package step_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic MODE_ODD_FIRST  = 1'b0;
    localparam logic MODE_EVEN_FIRST = 1'b1;

    // Values of the mode's preferred parity advance by 2, the other parity by 3.
    function automatic logic [1:0] step_incr(input logic lsb, input logic mode);
        step_incr = (lsb ^ ~mode) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/step_core.sv
// Parity-step counter core: loadable CW-bit register advancing by the mode-dependent step rule.
// next_value is the value the register takes on an enabled step.
module step_core
    import step_sched_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          enable,
    input  logic          mode,
    input  logic [CW-1:0] seed,
    output logic [CW-1:0] next_value
);

    logic [CW-1:0] value_r;

    // Step result, wrapping modulo 2^CW.
    always_comb begin
        next_value = value_r + CW'(step_incr(value_r[0], mode));
    end

    // Core register: load has priority over stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= {CW{1'b0}};
        end else if (load) begin
            value_r <= seed;
        end else if (enable) begin
            value_r <= next_value;
        end else begin
            value_r <= value_r;
        end
    end

endmodule

// File: rtl/step_counter_sched.sv
// Round-robin scheduler sharing one step_core among NREQ requesters.
// Each granted job loads a seed, runs a number of steps and reports the final value with its requester ID.
module step_counter_sched
    import step_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CW   = 4,
    parameter int SW   = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   req_seed,
    input  logic [NREQ-1:0]      req_mode,
    input  logic [NREQ*SW-1:0]   req_steps,
    input  logic                 abort,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [CW-1:0]        result
);

    localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_e          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [SW-1:0]   remaining_r;
    logic [CW-1:0]   job_seed_r;
    logic            job_mode_r;
    logic [SW-1:0]   job_steps_r;
    logic [IDW-1:0]  job_id_r;
    logic [CW-1:0]   result_r;
    logic [IDW-1:0]  done_id_r;

    logic            pick_valid_s;
    logic [IDW-1:0]  pick_idx_s;
    int              probe_idx_s;
    logic            grant_s;
    logic [NREQ-1:0] gnt_s;
    logic            core_load_s;
    logic            core_step_s;
    logic [CW-1:0]   core_next_s;

    // First asserted requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = {IDW{1'b0}};
        probe_idx_s  = 0;
        for (int k = 0; k < NREQ; k++) begin
            probe_idx_s = (int'(rr_ptr_r) + k) % NREQ;
            if (!pick_valid_s && req[probe_idx_s]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = IDW'(probe_idx_s);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Grant strobe: only from IDLE and never while abort is held.
    always_comb begin
        grant_s = (state_r == ST_IDLE) && !abort && pick_valid_s;
        if (grant_s) begin
            gnt_s = ONE_HOT_0 << pick_idx_s;
        end else begin
            gnt_s = {NREQ{1'b0}};
        end
    end

    assign core_load_s = (state_r == ST_LOAD) && !abort;
    assign core_step_s = (state_r == ST_RUN) && !abort;

    step_core #(
        .CW (CW)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (core_load_s),
        .enable     (core_step_s),
        .mode       (job_mode_r),
        .seed       (job_seed_r),
        .next_value (core_next_s)
    );

    // Job sequencing; result/done_id are captured on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {IDW{1'b0}};
            remaining_r <= {SW{1'b0}};
            job_seed_r  <= {CW{1'b0}};
            job_mode_r  <= MODE_ODD_FIRST;
            job_steps_r <= {SW{1'b0}};
            job_id_r    <= {IDW{1'b0}};
            result_r    <= {CW{1'b0}};
            done_id_r   <= {IDW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        job_seed_r  <= req_seed[pick_idx_s*CW +: CW];
                        job_mode_r  <= req_mode[pick_idx_s];
                        job_steps_r <= req_steps[pick_idx_s*SW +: SW];
                        job_id_r    <= pick_idx_s;
                        rr_ptr_r    <= (pick_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}}
                                                                      : pick_idx_s + IDW'(1);
                        state_r     <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (job_steps_r == {SW{1'b0}}) begin
                        result_r  <= job_seed_r;
                        done_id_r <= job_id_r;
                        state_r   <= ST_DONE;
                    end else begin
                        remaining_r <= job_steps_r;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                    end else if (remaining_r == SW'(1)) begin
                        remaining_r <= remaining_r - SW'(1);
                        result_r    <= core_next_s;
                        done_id_r   <= job_id_r;
                        state_r     <= ST_DONE;
                    end else begin
                        remaining_r <= remaining_r - SW'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_s;
    assign busy    = (state_r != ST_IDLE);
    assign done    = (state_r == ST_DONE);
    assign done_id = done_id_r;
    assign result  = result_r;

endmodule

// File: tb/tb_step_counter_sched.sv
// Scoreboard bench for step_counter_sched: directed scenarios followed by randomized traffic.
// Grants are predicted from a round-robin model; completions are predicted by replaying the step rule.
module tb_step_counter_sched;

    localparam int NREQ = 2;
    localparam int CW   = 4;
    localparam int SW   = 4;
    localparam int IDW  = 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*CW-1:0]   req_seed = '0;
    logic [NREQ-1:0]      req_mode = '0;
    logic [NREQ*SW-1:0]   req_steps = '0;
    logic                 abort = 1'b0;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic                 done;
    logic [IDW-1:0]       done_id;
    logic [CW-1:0]        result;

    step_counter_sched #(.NREQ(NREQ), .CW(CW), .SW(SW), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_seed  (req_seed),
        .req_mode  (req_mode),
        .req_steps (req_steps),
        .abort     (abort),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int res;
        int due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    // Reference model state (cycle-number bookkeeping, not FSM replication)
    int rr_m = 0;
    int busy_from = 0;
    int free_at = 0;
    int job_g = 0;
    int job_s = 0;
    bit job_live = 1'b0;
    int last_res = 0;
    int last_id = 0;
    bit keep[NREQ];
    bit granted_d[NREQ];

    function automatic int ref_run(int seed, int mode, int steps);
        int v = seed;
        for (int s = 0; s < steps; s++) begin
            if (mode == 1) v = v + ((v % 2 == 0) ? 2 : 3);
            else           v = v + ((v % 2 == 1) ? 2 : 3);
            v = v % (1 << CW);
        end
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rr_m = 0;
        busy_from = 0;
        free_at = 0;
        job_live = 1'b0;
        last_res = 0;
        last_id = 0;
        for (int i = 0; i < NREQ; i++) granted_d[i] = 1'b0;
    endtask

    task automatic set_job(int i, int seed, int mode, int steps);
        req[i] = 1'b1;
        req_seed[i*CW +: CW] = CW'(seed);
        req_mode[i] = mode[0];
        req_steps[i*SW +: SW] = SW'(steps);
    endtask

    // Called at a falling edge once the cycle's inputs are driven; returns at the next falling edge.
    task automatic tick();
        int pick = -1;
        int exp_gnt = 0;
        int idx;
        int s;
        #1;
        if (cyc >= free_at && !abort) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr_m + k) % NREQ;
                if (pick < 0 && req[idx]) pick = idx;
            end
        end
        if (pick >= 0) exp_gnt = 1 << pick;
        check("gnt", int'(gnt), exp_gnt);
        if (pick >= 0) begin
            s = int'(req_steps[pick*SW +: SW]);
            exp_q.push_back('{id: pick,
                              res: ref_run(int'(req_seed[pick*CW +: CW]), int'(req_mode[pick]), s),
                              due: cyc + s + 2});
            busy_from = cyc + 1;
            free_at = cyc + s + 3;
            job_g = cyc;
            job_s = s;
            job_live = 1'b1;
            rr_m = (pick + 1) % NREQ;
            granted_d[pick] = 1'b1;
        end else if (abort && job_live && cyc >= job_g + 1 && cyc <= job_g + job_s + 1) begin
            void'(exp_q.pop_back());
            free_at = cyc + 1;
            job_live = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (granted_d[i]) begin
                granted_d[i] = 1'b0;
                if (!keep[i]) req[i] = 1'b0;
            end
        end
    endtask

    task automatic idle_until_free();
        int budget = 100;
        while (cyc <= free_at && budget > 0) begin
            tick();
            budget--;
        end
        check("idle_budget", int'(budget > 0), 1);
    endtask

    // Monitor: every falling edge, compare completions against the scoreboard and outputs against the model.
    initial begin
        exp_t e;
        bit due_now;
        forever begin
            @(negedge clk);
            if (started && rst_n) begin
                due_now = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                check("busy", int'(busy), int'(cyc >= busy_from && cyc < free_at));
                check("done", int'(done), int'(due_now));
                if (due_now) begin
                    e = exp_q.pop_front();
                    if (done) begin
                        check("done_id", int'(done_id), e.id);
                        check("result", int'(result), e.res);
                        last_res = e.res;
                        last_id = e.id;
                    end
                end else if (!done) begin
                    check("result_hold", int'(result), last_res);
                    check("done_id_hold", int'(done_id), last_id);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            keep[i] = 1'b0;
            granted_d[i] = 1'b0;
        end
        #3;
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_result", int'(result), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        started = 1'b1;
        @(negedge clk);

        // Single job, mode 1: 4 -> 6 -> 9 -> 12
        set_job(0, 4, 1, 3);
        tick();
        idle_until_free();
        // Mode 0 with wrap: 13 -> 15 -> 1 -> 3
        set_job(0, 13, 0, 3);
        tick();
        idle_until_free();
        // Zero steps returns the seed
        set_job(1, 7, 0, 0);
        tick();
        idle_until_free();

        // Round-robin with both requests held continuously
        keep[0] = 1'b1;
        keep[1] = 1'b1;
        set_job(0, 2, 1, 2);
        set_job(1, 11, 0, 1);
        repeat (30) tick();
        keep[0] = 1'b0;
        keep[1] = 1'b0;
        repeat (20) tick();
        idle_until_free();

        // Abort in the second RUN cycle of a 5-step job, with another request pending
        set_job(0, 3, 1, 5);
        tick();
        set_job(1, 9, 1, 2);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        idle_until_free();

        // Asynchronous reset mid-RUN after rr_ptr has moved past requester 0
        set_job(0, 5, 1, 10);
        tick();
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_result", int'(result), 0);
        check("arst_done_id", int'(done_id), 0);
        check("arst_gnt", int'(gnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_job(0, 1, 0, 2);
        set_job(1, 6, 1, 1);
        tick();
        idle_until_free();
        idle_until_free();

        // Randomized traffic, including payload changes while waiting and kept requests
        for (int n = 0; n < 3000; n++) begin
            abort = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0)
                    set_job(i, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
                else if (req[i] && $urandom_range(0, 7) == 0)
                    set_job(i, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15));
                keep[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        abort = 1'b0;
        for (int i = 0; i < NREQ; i++) keep[i] = 1'b0;
        req = '0;
        idle_until_free();
        repeat (3) tick();
        check("queue_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_counter_sched.md
# step_counter_sched

- Round-robin scheduler that shares one parity-step counter core among `NREQ` requesters.
- Each granted job:
  - loads a seed into the core;
  - runs the core for a requested number of steps in the requested mode;
  - returns the final value with a one-cycle `done` pulse tagged by requester ID.
- Sits between client blocks and the step-counter datapath; it is the only block that drives the core's load/mode controls.

## Interface
- `NREQ`, default 2 — number of requesters (≥2).
- `CW`, default 4 — counter/seed/result width.
- `SW`, default 4 — step-count width.
- `IDW`, default $clog2(NREQ) — requester ID width.

- `clk`  in  1  — single clock, all state on rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `req`  in  NREQ  — per-requester job request; held until granted.
- `req_seed`  in  NREQ*CW  — packed seeds; slice i belongs to requester i.
- `req_mode`  in  NREQ  — per-requester step mode.
- `req_steps`  in  NREQ*SW  — packed step counts.
- `abort`  in  1  — synchronous job cancel.
- `gnt`  out  NREQ  — one-hot accept strobe, combinational, high for exactly one cycle per job.
- `busy`  out  1  — high in LOAD, RUN and DONE.
- `done`  out  1  — one-cycle completion pulse.
- `done_id`  out  IDW  — requester ID of completed job.
- `result`  out  CW  — final counter value.

## Operation
- Step rule, applied once per RUN cycle, mod 2^CW wrap:
  - mode=1: even value +2, odd value +3.
  - mode=0: odd value +2, even value +3.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any `req` and `abort`=0: grant the first asserted requester at or after `rr_ptr`, searching upward and wrapping.
  - `gnt[i]`=1 in that cycle. At the edge, capture seed/mode/steps/ID, set `rr_ptr`=(i+1) mod NREQ, go to LOAD.
  - `abort`=1 in IDLE suppresses `gnt` and has no other effect.
- LOAD: core <= seed. If steps==0 go to DONE, else set `remaining`=steps and go to RUN.
- RUN:
  - Core steps every cycle and `remaining` decrements.
  - The edge on which `remaining`==1 performs the last step and goes to DONE.
- DONE:
  - `done`=1. `result` and `done_id` are registered on entry to DONE and hold until the next DONE.
  - Returns to IDLE next edge. A new grant is possible only from IDLE, so back-to-back jobs have a 1-cycle IDLE gap.
- `abort` in LOAD or RUN:
  - Go to IDLE at the next edge with no `done`.
  - `result`/`done_id` keep their previous values; `rr_ptr` stays advanced.
- `abort` in DONE is ignored; the job completes.
- Requests arriving while `busy` wait; payload is sampled only at the grant edge.
- Requester i drops `req[i]` after the edge where `gnt[i]`=1. If it keeps `req` high, that is a new job, granted per round-robin.

## Timing
- Reset values:
  - state=IDLE, core=0, `remaining`=0, `rr_ptr`=0.
  - `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `result`=0.
  - Async assertion clears all state immediately; a job in flight is discarded with no `done`.
- Latency, grant cycle at T (gnt high):
  - LOAD at T+1, RUN at T+2 .. T+1+S.
  - `done` high in cycle T+S+2; total S+2 cycles after grant.
  - S=0: `done` at T+2 with `result`=seed.
- `busy` is high from T+1 through the DONE cycle inclusive.
- Maximum S = 2^SW−1. Core value wraps freely; there are no overflow flags.

## Structure
- Shared package `step_sched_pkg`:
  - FSM state enum (IDLE/LOAD/RUN/DONE);
  - MODE_ODD_FIRST=1'b0, MODE_EVEN_FIRST=1'b1 constants.
- Sub-module `step_core`: CW-bit register with load/enable/mode and the step rule above; the scheduler instantiates one.
- Round-robin pick is local combinational logic in the top level.

## Test plan
- Single job: req0, seed=4, mode=1, steps=3 → 4→6→9→12; `done` at grant+5, `result`=12, `done_id`=0.
- Mode 0 with wrap, CW=4: seed=13, mode=0, steps=3 → 13→15→1→3; `result`=3.
- Zero steps: seed=7, steps=0 → `done` at grant+2, `result`=7.
- Round-robin: req0 and req1 held high continuously.
  - Grants alternate 0,1,0,1.
  - Each `done_id` matches its grant.
  - 1 IDLE cycle between each DONE and the next `gnt`.
- Abort: `abort` in the 2nd RUN cycle of a steps=5 job.
  - IDLE next cycle, no `done`, `result` unchanged.
  - Next pending request is granted from IDLE.
- Async reset: `rst_n` low mid-RUN.
  - All outputs go to reset values immediately; no `done`.
  - After release, the first grant goes to the lowest asserted index.
